// File: rtl/stopwatch_timer.sv
// Four-digit BCD stopwatch (SS.hh) driven by start/stop and lap/clear buttons.
// Define STOPWATCH_LAP_HOLD_EN to build in the LAP state that freezes the display.
module stopwatch_timer #(
  parameter int TICK_DIVIDE = 1_250_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start_stop,
  input  logic        btn_lap_clear,
  output logic [15:0] number,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);

  localparam int PW = $clog2(TICK_DIVIDE);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIVIDE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
`ifdef STOPWATCH_LAP_HOLD_EN
    ,LAP  = 2'd3
`endif
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [15:0]   count, count_nxt, num_nxt;
  logic          ovf_nxt, wrap, clear, tick, counting, running_nxt;

  logic ss_p0, ss_p1, ss_prev, ss_arm;
  logic lc_p0, lc_p1, lc_prev, lc_arm;
  logic rdy_p0, rdy_p1;
  logic ss_evt, lc_evt;

  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] >= 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  // Stage boundary: button synchronizers and edge detectors. A button is only
  // armed once its synchronized level has been seen low after reset, so a
  // button held through reset release cannot fire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_p0   <= 1'b0;
      ss_p1   <= 1'b0;
      ss_prev <= 1'b0;
      ss_arm  <= 1'b0;
      lc_p0   <= 1'b0;
      lc_p1   <= 1'b0;
      lc_prev <= 1'b0;
      lc_arm  <= 1'b0;
      rdy_p0  <= 1'b0;
      rdy_p1  <= 1'b0;
    end else begin
      ss_p0   <= btn_start_stop;
      ss_p1   <= ss_p0;
      ss_prev <= ss_p1;
      ss_arm  <= ss_arm | (rdy_p1 & ~ss_p1);
      lc_p0   <= btn_lap_clear;
      lc_p1   <= lc_p0;
      lc_prev <= lc_p1;
      lc_arm  <= lc_arm | (rdy_p1 & ~lc_p1);
      rdy_p0  <= 1'b1;
      rdy_p1  <= rdy_p0;
    end
  end

  assign ss_evt = ss_p1 & ~ss_prev & ss_arm;
  assign lc_evt = lc_p1 & ~lc_prev & lc_arm;

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    case (state)
      IDLE:  if (ss_evt) state_nxt = RUN;
      RUN: begin
        if (ss_evt) state_nxt = PAUSE;
`ifdef STOPWATCH_LAP_HOLD_EN
        else if (lc_evt) state_nxt = LAP;
`endif
      end
      PAUSE: begin
        if (ss_evt) begin
          state_nxt = RUN;
        end else if (lc_evt) begin
          state_nxt = IDLE;
          clear     = 1'b1;
        end
      end
`ifdef STOPWATCH_LAP_HOLD_EN
      LAP: begin
        if (ss_evt)      state_nxt = PAUSE;
        else if (lc_evt) state_nxt = RUN;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  assign counting    = (state == RUN) || (state == LAP);
  assign running_nxt = (state_nxt == RUN) || (state_nxt == LAP);
`else
  assign counting    = (state == RUN);
  assign running_nxt = (state_nxt == RUN);
`endif
  assign tick = counting && (presc == PRESC_MAX);

  always_comb begin
    count_nxt = count;
    ovf_nxt   = overflow;
    wrap      = 1'b0;
    presc_nxt = presc;
    if (clear) begin
      count_nxt = 16'h0000;
      ovf_nxt   = 1'b0;
    end else if (tick) begin
      {wrap, count_nxt} = bcd_inc(count);
      if (wrap) ovf_nxt = 1'b1;
    end
    if (clear || state == IDLE) presc_nxt = '0;
    else if (tick)              presc_nxt = '0;
    else if (counting)          presc_nxt = presc + PW'(1);
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic [15:0] lap_hold, lap_nxt;

  always_comb begin
    lap_nxt = lap_hold;
    if (state == RUN && state_nxt == LAP) lap_nxt = count_nxt;
    num_nxt = (state_nxt == LAP) ? lap_nxt : count_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_hold   <= 16'h0000;
      lap_active <= 1'b0;
    end else begin
      lap_hold   <= lap_nxt;
      lap_active <= (state_nxt == LAP);
    end
  end
`else
  assign num_nxt    = count_nxt;
  assign lap_active = 1'b0;
`endif

  // Stage boundary: state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      presc    <= '0;
      count    <= 16'h0000;
      overflow <= 1'b0;
      number   <= 16'h0000;
      running  <= 1'b0;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      count    <= count_nxt;
      overflow <= ovf_nxt;
      number   <= num_nxt;
      running  <= running_nxt;
    end
  end

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed scoreboard bench for stopwatch_timer with TICK_DIVIDE=4.
module tb_stopwatch_timer;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bss = 1'b0;
  logic        blc = 1'b0;
  logic [15:0] number;
  logic        running, lap_active, overflow;

  int tests = 0;
  int fails = 0;

  string       tag_q[$];
  logic [18:0] exp_q[$];

  stopwatch_timer #(.TICK_DIVIDE(TD)) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_start_stop (bss),
    .btn_lap_clear  (blc),
    .number         (number),
    .running        (running),
    .lap_active     (lap_active),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic expect_out(input string tag, input logic [15:0] n,
                            input logic r, input logic l, input logic o);
    tag_q.push_back(tag);
    exp_q.push_back({n, r, l, o});
  endtask

  task automatic check_out();
    string       t;
    logic [18:0] e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    tests++;
    assert (number === e[18:3]) else begin
      fails++;
      $error("FAIL %s number got %h want %h", t, number, e[18:3]);
    end
    tests++;
    assert (running === e[2]) else begin
      fails++;
      $error("FAIL %s running got %b want %b", t, running, e[2]);
    end
    tests++;
    assert (lap_active === e[1]) else begin
      fails++;
      $error("FAIL %s lap_active got %b want %b", t, lap_active, e[1]);
    end
    tests++;
    assert (overflow === e[0]) else begin
      fails++;
      $error("FAIL %s overflow got %b want %b", t, overflow, e[0]);
    end
  endtask

  task automatic sample(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Rise the selected buttons before an edge; returns just after the edge on
  // which the state register takes the resulting transition.
  task automatic press(input bit ss, input bit lc);
    @(negedge clk);
    if (ss) bss = 1'b1;
    if (lc) blc = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bss = 1'b0;
    blc = 1'b0;
  endtask

  initial begin
    #23;
    expect_out("reset_hold", 16'h0000, 0, 0, 0);
    check_out();
    @(negedge clk);
    rst = 1'b1;
    expect_out("first_edge", 16'h0000, 0, 0, 0);
    sample(1);
    check_out();
    sample(5);

    press(1, 0);
    expect_out("count_40", 16'h0040, 1, 0, 0);
    sample(40 * TD);
    check_out();
    expect_out("carry_0999", 16'h0999, 1, 0, 0);
    sample(959 * TD);
    check_out();
    expect_out("carry_1000", 16'h1000, 1, 0, 0);
    sample(TD);
    check_out();
    expect_out("pre_wrap", 16'h9999, 1, 0, 0);
    sample(8999 * TD);
    check_out();
    expect_out("wrap", 16'h0000, 1, 0, 1);
    sample(TD);
    check_out();

    sample(123 * TD - 1);
    press(1, 0);
    expect_out("pause_hold", 16'h0123, 0, 0, 1);
    check_out();
    expect_out("pause_still", 16'h0123, 0, 0, 1);
    sample(20);
    check_out();
    press(1, 0);
    expect_out("resume_edge", 16'h0123, 1, 0, 1);
    check_out();
    expect_out("resume_plus1", 16'h0123, 1, 0, 1);
    sample(1);
    check_out();
    expect_out("resume_tick", 16'h0124, 1, 0, 1);
    sample(1);
    check_out();
    press(1, 0);
    expect_out("pause2", 16'h0124, 0, 0, 1);
    check_out();
    press(0, 1);
    expect_out("clear", 16'h0000, 0, 0, 0);
    check_out();
    expect_out("idle_stays", 16'h0000, 0, 0, 0);
    sample(12);
    check_out();

    press(1, 0);
    sample(5 * TD);
    press(1, 1);
    expect_out("both_pause", 16'h0005, 0, 0, 0);
    check_out();
    sample(4);
    press(0, 1);
    expect_out("both_clear", 16'h0000, 0, 0, 0);
    check_out();
    sample(4);

    press(1, 0);
`ifdef STOPWATCH_LAP_HOLD_EN
    sample(250 * TD - 3);
    press(0, 1);
    expect_out("lap_freeze", 16'h0250, 1, 1, 0);
    check_out();
    expect_out("lap_hold30", 16'h0250, 1, 1, 0);
    sample(30 * TD);
    check_out();
    press(0, 1);
    expect_out("lap_release", 16'h0280, 1, 0, 0);
    check_out();
`else
    sample(10 * TD);
    press(0, 1);
    expect_out("lap_ignored", 16'h0010, 1, 0, 0);
    check_out();
    expect_out("lap_ignored_run", 16'h0011, 1, 0, 0);
    sample(1);
    check_out();
`endif
    press(1, 0);
    sample(4);
    press(0, 1);
    expect_out("lap_clear_idle", 16'h0000, 0, 0, 0);
    check_out();
    sample(4);

    press(1, 0);
    expect_out("pre_reset", 16'h0567, 1, 0, 0);
    sample(567 * TD);
    check_out();
    #2;
    rst = 1'b0;
    bss = 1'b1;
    #1;
    expect_out("async_reset", 16'h0000, 0, 0, 0);
    check_out();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    expect_out("held_idle", 16'h0000, 0, 0, 0);
    sample(10);
    check_out();
    bss = 1'b0;
    sample(4);
    press(1, 0);
    expect_out("repress_run", 16'h0000, 1, 0, 0);
    check_out();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stopwatch_timer.md
STOPWATCH_TIMER -- requirements
Module: stopwatch_timer

Interface
REQ-001 SHALL have parameter TICK_DIVIDE, default 1_250_000, meaning clk cycles per 0.01 s count tick (100 Hz at 125 MHz); legal range 2..2^24.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port btn_start_stop  input  1  debounced start/stop button level, asynchronous to clk.
REQ-005 SHALL have port btn_lap_clear  input  1  debounced lap/clear button level, asynchronous to clk.
REQ-006 SHALL have port number  output  16  packed BCD time for the 4-digit display; [3:0] hundredths, [7:4] tenths, [11:8] seconds units, [15:12] seconds tens.
REQ-007 SHALL have port running  output  1  high while the count advances.
REQ-008 SHALL have port lap_active  output  1  high while the displayed value is frozen.
REQ-009 SHALL have port overflow  output  1  sticky flag, set when the count wraps 99.99 -> 00.00.

Function
REQ-010 SHALL pass each button through a 2-flop synchronizer, then a rising-edge detector; one press yields exactly one single-cycle event.
REQ-011 SHALL update the state register on the 3rd rising clk edge after a button level rises with setup to the 1st edge.
REQ-012 SHALL implement states IDLE, RUN, PAUSE, LAP.
REQ-013 IDLE: start_stop -> RUN; lap_clear -> no effect.
REQ-014 RUN: start_stop -> PAUSE; lap_clear -> LAP (macro on) or no effect (macro off).
REQ-015 LAP: start_stop -> PAUSE and release the freeze; lap_clear -> RUN and release the freeze.
REQ-016 PAUSE: start_stop -> RUN; lap_clear -> IDLE, clearing count, prescaler and overflow in the same edge.
REQ-017 SHALL give start_stop priority when both events occur in the same cycle; the lap_clear event is discarded.
REQ-018 SHALL run the prescaler 0..TICK_DIVIDE-1 only in RUN and LAP, hold it in PAUSE (fraction preserved), and zero it in IDLE.
REQ-019 SHALL assert the internal tick for one cycle when the prescaler equals TICK_DIVIDE-1; the count increments on that same edge.
REQ-020 SHALL hold the count as 4 BCD digits, each 0..9, with ripple carry; digits never take values A..F.
REQ-021 SHALL wrap 99.99 -> 00.00 on a tick, set overflow, and keep running.
REQ-022 SHALL drive number from the live count except in LAP, where it shows the count latched on the RUN->LAP edge.
REQ-023 SHALL register all outputs; running = RUN|LAP, lap_active = LAP.

Reset
REQ-024 SHALL, while rst=0, force state IDLE, count 0000, prescaler 0, synchronizer and edge flops 0, lap latch 0000.
REQ-025 SHALL output number=16'h0000, running=0, lap_active=0, overflow=0 during reset and on the first edge after release.
REQ-026 SHALL, on reset mid-run or mid-LAP, abandon all state immediately (no completion of a pending tick or event).
REQ-027 SHALL NOT generate an event from a button already held high at reset release (edge flops reset low, then synchronized level high: no event until the button is released and pressed again).

Configuration
REQ-028 SHALL compile the LAP state, lap latch and lap_active logic in only when STOPWATCH_LAP_HOLD_EN is defined.
REQ-029 SHALL, without STOPWATCH_LAP_HOLD_EN, ignore lap_clear in RUN, tie lap_active to 0, and keep all other behaviour identical.

Verification
REQ-030 SHALL verify counting: TICK_DIVIDE=4, press start_stop, 40 ticks -> number=16'h0040, running=1.
REQ-031 SHALL verify carry: 999 ticks from zero -> 16'h0999; 1 more -> 16'h1000; from 16'h9999 one tick -> 16'h0000 and overflow=1.
REQ-032 SHALL verify pause/clear: pause at 16'h0123 with prescaler=2 -> number holds; resume -> next tick after 2 cycles; pause + lap_clear -> 16'h0000, overflow=0, IDLE.
REQ-033 SHALL verify lap (macro on): lap_clear at 16'h0250 -> number frozen at 16'h0250 while the internal count advances 30 ticks; lap_clear -> number=16'h0280.
REQ-034 SHALL verify simultaneous events: start_stop and lap_clear rise in the same cycle in RUN -> PAUSE, no LAP; macro off: lap_clear in RUN -> no change, lap_active=0.
REQ-035 SHALL verify reset: rst low mid-run at 16'h0567 -> all outputs 0 asynchronously; button held through release -> remains IDLE.
